seq_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one 4-phase sequencing resource (phase A -> phase B or C -> phase D) among N_REQ requesters.
- Grants one requester at a time and drives the resource's branch select (x1) from that requester's latched mode bit.
- Holds the grant for PASSES complete passes, then rotates priority.
- Sits between the requester ports and the shared sequencer.

---
 rtl/seq_pkg.sv | 26 ++
 rtl/rr_pick.sv | 38 +++
 rtl/seq_rr_scheduler.sv | 125 ++++++++++++
 tb/tb_seq_rr_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : seq_pkg
// Brief  : State encoding and width helper shared by the round-robin scheduler
// Rev    : 1.0
// ---------------------------------------------------------------------------
package seq_pkg;

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_PA   = 3'd1;
  localparam logic [2:0] c_ST_PB   = 3'd2;
  localparam logic [2:0] c_ST_PC   = 3'd3;
  localparam logic [2:0] c_ST_PD   = 3'd4;

  // Ceiling log2 for elaboration-time widths; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rr_pick
// Brief  : Combinational rotate-priority encoder; first set bit at or after
//          i_ptr (wrapping) wins
// Rev    : 1.0
// ---------------------------------------------------------------------------
module rr_pick import seq_pkg::*; #(
  parameter int N_REQ = 4,
  parameter int IDX_W = clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  localparam logic [IDX_W:0] c_N = (IDX_W+1)'(N_REQ);

  logic [IDX_W:0] w_pos;

  // Scan from the farthest offset back to ptr so the closest hit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_pos   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      w_pos = {1'b0, i_ptr} + (IDX_W+1)'(i);
      if (w_pos >= c_N) w_pos = w_pos - c_N;
      if (i_req[w_pos[IDX_W-1:0]]) begin
        o_valid = 1'b1;
        o_index = w_pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/seq_rr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : seq_rr_scheduler
// Brief  : Round-robin owner of a shared A -> (B|C) -> D sequencer; each grant
//          runs PASSES full passes before priority rotates
// Rev    : 1.0
// ---------------------------------------------------------------------------
module seq_rr_scheduler import seq_pkg::*; #(
  parameter int N_REQ  = 4,
  parameter int PASSES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         mode,
  output logic [N_REQ-1:0]         gnt,
  output logic                     x1,
  output logic                     outp,
  output logic                     busy,
  output logic                     done,
  output logic [clog2(N_REQ)-1:0]  gnt_id
);

  localparam int               c_IDW       = clog2(N_REQ);
  localparam int               c_PCW       = clog2(PASSES) + 1;
  localparam logic [c_PCW-1:0] c_LAST_PASS = c_PCW'(PASSES - 1);
  localparam logic [c_IDW-1:0] c_LAST_ID   = c_IDW'(N_REQ - 1);

  logic [2:0]       r_state;
  logic [c_IDW-1:0] r_ptr;
  logic [c_PCW-1:0] r_pass_cnt;
  logic             r_mode_q;

  logic [c_IDW-1:0] w_ptr_next;
  logic [c_IDW-1:0] w_pick_ptr;
  logic [c_IDW-1:0] w_pick_idx;
  logic             w_pick_valid;
  logic             w_last_pass;
  logic             w_grant_end;
  logic             w_arb_go;

  assign w_ptr_next  = (gnt_id == c_LAST_ID) ? '0 : gnt_id + c_IDW'(1);
  assign w_last_pass = (r_pass_cnt == c_LAST_PASS);
  assign w_grant_end = (r_state == c_ST_PD) && w_last_pass;
  // At the end of a grant the search already starts past the finishing owner,
  // so it is only re-picked when nobody else is asking.
  assign w_pick_ptr  = (r_state == c_ST_PD) ? w_ptr_next : r_ptr;
  assign w_arb_go    = w_pick_valid && ((r_state == c_ST_IDLE) || w_grant_end);

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (c_IDW)
  ) u_pick (
    .i_req   (req),
    .i_ptr   (w_pick_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= c_ST_IDLE;
      r_ptr      <= '0;
      r_pass_cnt <= '0;
      r_mode_q   <= 1'b0;
      gnt        <= '0;
      gnt_id     <= '0;
      x1         <= 1'b0;
      outp       <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_grant_end) r_ptr <= w_ptr_next;

      if (w_arb_go) begin
        r_state    <= c_ST_PA;
        gnt        <= N_REQ'(1) << w_pick_idx;
        gnt_id     <= w_pick_idx;
        r_mode_q   <= mode[w_pick_idx];
        x1         <= mode[w_pick_idx];
        r_pass_cnt <= '0;
        outp       <= 1'b1;
        busy       <= 1'b1;
      end else begin
        case (r_state)
          c_ST_IDLE: begin
            r_state <= c_ST_IDLE;
          end
          c_ST_PA: begin
            r_state <= r_mode_q ? c_ST_PB : c_ST_PC;
            outp    <= r_mode_q;
          end
          c_ST_PB, c_ST_PC: begin
            r_state <= c_ST_PD;
            outp    <= 1'b0;
            done    <= w_last_pass;
          end
          c_ST_PD: begin
            if (!w_last_pass) begin
              r_state    <= c_ST_PA;
              r_pass_cnt <= r_pass_cnt + c_PCW'(1);
              outp       <= 1'b1;
            end else begin
              r_state <= c_ST_IDLE;
              gnt     <= '0;
              x1      <= 1'b0;
              outp    <= 1'b0;
              busy    <= 1'b0;
            end
          end
          default: begin
            r_state <= c_ST_IDLE;
            gnt     <= '0;
            x1      <= 1'b0;
            outp    <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_rr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_seq_rr_scheduler
// Brief  : Scoreboard bench for seq_rr_scheduler against a grant-schedule model
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_seq_rr_scheduler;

  localparam int N_REQ  = 4;
  localparam int PASSES = 2;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       x1;
    logic       outp;
    logic       busy;
    logic       done;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] mode;
  logic [3:0] gnt;
  logic       x1, outp, busy, done;
  logic [1:0] gnt_id;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t sb_q[$];

  // Reference model: a grant is a list of outp values, one per cycle.
  bit m_busy;
  int m_owner;
  bit m_mode;
  int m_ptr;
  bit m_sched[$];

  always #5 clk = ~clk;

  seq_rr_scheduler #(
    .N_REQ  (N_REQ),
    .PASSES (PASSES)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .mode   (mode),
    .gnt    (gnt),
    .x1     (x1),
    .outp   (outp),
    .busy   (busy),
    .done   (done),
    .gnt_id (gnt_id)
  );

  function automatic void model_reset();
    m_busy  = 1'b0;
    m_owner = 0;
    m_mode  = 1'b0;
    m_ptr   = 0;
    m_sched.delete();
  endfunction

  function automatic void model_step();
    exp_t e;
    bit   found;
    e = '0;
    if (!reset) begin
      model_reset();
      sb_q.push_back(e);
      return;
    end
    if (m_busy && m_sched.size() == 0) begin
      m_ptr  = (m_owner + 1) % N_REQ;
      m_busy = 1'b0;
    end
    if (!m_busy) begin
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
        int k;
        k = (m_ptr + i) % N_REQ;
        if (!found && req[k]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = k;
          m_mode  = mode[k];
          for (int p = 0; p < PASSES; p++) begin
            m_sched.push_back(1'b1);
            m_sched.push_back(m_mode);
            m_sched.push_back(1'b0);
          end
        end
      end
    end
    e.gnt_id = 2'(m_owner);
    if (m_busy) begin
      e.outp = m_sched.pop_front();
      e.gnt  = 4'b0001 << m_owner;
      e.x1   = m_mode;
      e.busy = 1'b1;
      e.done = (m_sched.size() == 0);
    end
    sb_q.push_back(e);
  endfunction

  task automatic tick(input logic rst_v, input logic [3:0] r, input logic [3:0] m);
    reset = rst_v;
    req   = r;
    mode  = m;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  // Reset lands mid-cycle, so the already-scheduled sample must read cleared.
  task automatic tick_async_rst(input logic [3:0] r, input logic [3:0] m);
    req  = r;
    mode = m;
    @(posedge clk);
    model_step();
    #2;
    reset = 1'b0;
    model_reset();
    sb_q.delete();
    sb_q.push_back(exp_t'(0));
    @(negedge clk);
    #1;
  endtask

  initial begin : monitor
    exp_t got;
    exp_t exp_v;
    @(posedge clk);
    forever begin
      @(negedge clk);
      got = {gnt, gnt_id, x1, outp, busy, done};
      n_checks++;
      if (sb_q.size() == 0) begin
        $display("FAIL scoreboard_empty at %0t: got %h, no expectation queued", $time, got);
      end else begin
        exp_v = sb_q.pop_front();
        if (got !== exp_v)
          $display("FAIL outputs at %0t: got gnt=%b id=%0d x1=%b outp=%b busy=%b done=%b, want gnt=%b id=%0d x1=%b outp=%b busy=%b done=%b",
                   $time, got.gnt, got.gnt_id, got.x1, got.outp, got.busy, got.done,
                   exp_v.gnt, exp_v.gnt_id, exp_v.x1, exp_v.outp, exp_v.busy, exp_v.done);
        else
          n_pass++;
      end
    end
  end

  initial begin : stimulus
    reset = 1'b0;
    req   = '0;
    mode  = '0;
    model_reset();

    repeat (3)  tick(1'b0, 4'b0000, 4'b0000);
    repeat (10) tick(1'b1, 4'b0000, 4'b0000);

    // Single requester, B branch, re-granted without a bubble.
    repeat (14) tick(1'b1, 4'b0001, 4'b0001);
    repeat (8)  tick(1'b1, 4'b0000, 4'b0000);

    // All requesting, C branch, full rotation.
    repeat (30) tick(1'b1, 4'b1111, 4'b0000);
    repeat (8)  tick(1'b1, 4'b0000, 4'b0000);

    // One-cycle pulse still earns a full grant.
    tick(1'b1, 4'b0100, 4'b0100);
    repeat (10) tick(1'b1, 4'b0000, 4'b0100);

    // Mode flipped mid-grant is ignored until the next grant.
    tick(1'b1, 4'b0100, 4'b0100);
    repeat (3) tick(1'b1, 4'b0000, 4'b0100);
    repeat (4) tick(1'b1, 4'b0000, 4'b0000);
    tick(1'b1, 4'b0100, 4'b0000);
    repeat (8) tick(1'b1, 4'b0000, 4'b0000);

    // Reset during PB of the second pass, then release with a new requester.
    tick(1'b1, 4'b1000, 4'b1000);
    repeat (3) tick(1'b1, 4'b0000, 4'b1000);
    tick_async_rst(4'b0000, 4'b1000);
    repeat (2) tick(1'b0, 4'b0010, 4'b0000);
    repeat (8) tick(1'b1, 4'b0010, 4'b0000);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] r;
      logic [3:0] m;
      r = 4'($urandom);
      m = 4'($urandom);
      if ($urandom_range(0, 3) == 0) r = '0;
      if ($urandom_range(0, 79) == 0) begin
        tick_async_rst(r, m);
        tick(1'b0, r, m);
      end else begin
        tick(1'b1, r, m);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
